usb_wb_bridge: RTL and testbench
================================

# usb_wb_bridge

Wishbone-style slave that sits directly upstream of the `usb` core top level. It translates 32-bit CPU accesses into two core-side interfaces: the core's 16-bit `bus_*` register / EP-status handshake, and the core's EP buffer ports (with `EPDW=32`, so `EPAW=9`). It sequences the core's cyc/ack protocol, including dropping `bus_cyc` after ack, and optionally bounds stalled core accesses with a timeout.

## Interface
Parameters:
- `ADDR_MSB`, 4'h3: value driven on `bus_addr[15:12]`; must equal the core's `ADDR_MSB`.
- `TIMEOUT`, 255: cycles to wait for `bus_ack` before abort. Used only with `USB_WB_TIMEOUT_EN`. Range 1..255.

Ports:
- `clk`  in  1  single clock for the block, the core bus and the EP buffer side (core `ep_clk` tied to `clk`).
- `rst_n`  in  1  asynchronous, active-low reset.
- `wb_addr`  in  16  word address; `[15:14]` selects the window.
- `wb_wdata`  in  32  write data.
- `wb_rdata`  out  32  read data; valid only while `wb_ack`=1, else 0.
- `wb_we`  in  1  write enable.
- `wb_cyc`  in  1  request; held until `wb_ack`.
- `wb_ack`  out  1  one-cycle completion pulse.
- `bus_addr`  out  16  `{ADDR_MSB, wb_addr[11:0]}`.
- `bus_din`  out  16  `wb_wdata[15:0]`.
- `bus_dout`  in  16  core read data.
- `bus_cyc`, `bus_we`  out  1  core request / direction.
- `bus_ack`  in  1  core ack.
- `ep_tx_addr_0`  out  9.
- `ep_tx_data_0`  out  32.
- `ep_tx_we_0`  out  1.
- `ep_rx_addr_0`  out  9.
- `ep_rx_data_1`  in  32.
- `ep_rx_re_0`  out  1.
- `err_timeout`  out  1  sticky; set on abort, cleared only by reset.

## Operation
Window decode on `wb_addr[15:14]`:
- 00: core register / EP status.
- 01: EP TX buffer, write-only; reads return 0.
- 10: EP RX buffer, read-only; writes are dropped but acked.
- 11: unmapped; acked, read returns 0.

FSM states and transitions:
- IDLE: accepts `wb_cyc`=1 only when `wb_ack`=0. This forces one dead cycle between transactions.
- CORE: entered from IDLE for window 00. Drives `bus_cyc`=1 with `bus_addr`, `bus_we` and `bus_din` registered and held constant. On `bus_ack`=1 it latches `bus_dout` into `wb_rdata[15:0]` (`[31:16]`=0) and goes to ACK.
- TXW: entered from IDLE for window 01 with `wb_we`=1. Pulses `ep_tx_we_0` for one cycle with `ep_tx_addr_0=wb_addr[8:0]` and `ep_tx_data_0=wb_wdata`, then goes to ACK.
- RXR: entered from IDLE for window 10 with `wb_we`=0. Pulses `ep_rx_re_0` with `ep_rx_addr_0=wb_addr[8:0]`, then goes to RXD.
- RXD: captures `ep_rx_data_1` into `wb_rdata`, then goes to ACK.
- ACK: `wb_ack`=1 for exactly one cycle, `bus_cyc`=0, then returns to IDLE.
- Any other window/direction goes from IDLE straight to ACK with `wb_rdata`=0.

Other rules:
- `bus_cyc` is deasserted in the cycle after `bus_ack` is sampled. This prevents a repeated CSR strobe in the core.
- If `wb_cyc` drops mid-transaction, the bridge still completes the core/EP access and pulses `wb_ack`; the master ignores that ack.
- Reset values: all outputs 0 except `bus_addr[15:12]`=`ADDR_MSB`. FSM resets to IDLE, `err_timeout`=0.
- Reset asserted mid-transaction: `bus_cyc`, `ep_*_we/re` and `wb_ack` go to 0 immediately (async).

## Timing
Wishbone request sampled at edge N:
- Window 01 write: `ep_tx_we_0` high N..N+1; `wb_ack` high N+1..N+2. Latency 2 cycles.
- Window 10 read: `ep_rx_re_0` high N..N+1; data captured at N+2; `wb_ack` high N+2..N+3. Latency 3 cycles.
- Window 00: `bus_cyc` rises after N. `bus_ack` sampled at edge M gives `bus_cyc`=0 and `wb_ack`=1 in M..M+1. For CSR accesses the core acks at M=N+2, so latency is 3 cycles. EP-status reads take 6+ cycles, depending on core arbitration.
- Minimum spacing between transactions: 1 idle cycle after each `wb_ack`.

## Configuration
- `USB_WB_TIMEOUT_EN` defined:
  - An 8-bit counter in CORE loads `TIMEOUT` on entry and decrements each cycle without `bus_ack`.
  - At 0 the access is aborted: `bus_cyc`=0, `wb_rdata`=32'hFFFFFFFF, `err_timeout`=1, go to ACK.
  - `bus_ack` and expiry in the same cycle: `bus_ack` wins, no error.
- Undefined: no counter is built, CORE waits indefinitely, and `err_timeout` is tied to 0.

## Test plan
- Reset with `rst_n`=0 mid-CORE → `bus_cyc`=0 and `wb_ack`=0 asynchronously; after release, FSM is in IDLE and `bus_addr`=16'h3000.
- Write 0x0000C012 to wb addr 0x0000 against a core model → `bus_addr`=0x3000, `bus_din`=0xC012, `bus_we`=1; `bus_cyc` drops the cycle after `bus_ack`; exactly one CSR write seen; `wb_ack` 3 cycles after request.
- Write 0xA5A55A5A to 0x4012 → `ep_tx_addr_0`=0x012, `ep_tx_data_0`=0xA5A55A5A, one `ep_tx_we_0` pulse; `wb_ack` at +2.
- RX buffer model returns 0x12345678 at address 0x1FF; read 0x81FF → `wb_rdata`=0x12345678 at `wb_ack`, +3 cycles.
- With `USB_WB_TIMEOUT_EN` and `TIMEOUT`=10, `bus_ack` never asserted → `wb_ack` after 10 wait cycles with `wb_rdata`=0xFFFFFFFF and `err_timeout`=1. A second run with `bus_ack` in the expiry cycle → normal data, `err_timeout` unchanged.
- Back-to-back requests with `wb_cyc` held high → one idle cycle between `wb_ack` pulses; read of 0xC000 returns 0; write to 0x8000 produces no `ep_rx_re_0`.

Source files
------------

// File: rtl/usb_wb_bridge.sv
// usb_wb_bridge: 32-bit Wishbone-style slave in front of the usb core.
// It decodes four address windows: core registers over the 16-bit bus_*
// handshake, the EP TX buffer (write-only), the EP RX buffer (read-only),
// and an unmapped window.
// Optional feature macro: USB_WB_TIMEOUT_EN. When defined, a stalled core
// access is aborted after TIMEOUT cycles without bus_ack.
module usb_wb_bridge #(
  parameter logic [3:0] ADDR_MSB = 4'h3,
  parameter int         TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] wb_addr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic        wb_ack,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_din,
  input  logic [15:0] bus_dout,
  output logic        bus_cyc,
  output logic        bus_we,
  input  logic        bus_ack,
  output logic [8:0]  ep_tx_addr_0,
  output logic [31:0] ep_tx_data_0,
  output logic        ep_tx_we_0,
  output logic [8:0]  ep_rx_addr_0,
  input  logic [31:0] ep_rx_data_1,
  output logic        ep_rx_re_0,
  output logic        err_timeout
);

  typedef enum logic [2:0] {IDLE, CORE, TXW, RXR, RXD, ACK} state_t;

  state_t      state, state_nxt;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] rdata_q, rdata_nxt;
  logic        load;
  logic        abort;

  // Address bits 13:12 are don't-care inside every window.
  logic unused;
  assign unused = &{1'b0, wb_addr[13:12]};

  // A request is taken only from IDLE, which also gives the dead cycle
  // after every ack.
  assign load = (state == IDLE) && wb_cyc && !wb_ack;

  // Strobes are pure state decodes, so an async reset of the state
  // register drops them immediately.
  assign wb_ack       = (state == ACK);
  assign bus_cyc      = (state == CORE);
  assign ep_tx_we_0   = (state == TXW);
  assign ep_rx_re_0   = (state == RXR);
  assign wb_rdata     = wb_ack ? rdata_q : 32'h0;
  assign bus_addr     = {ADDR_MSB, addr_q};
  assign bus_din      = wdata_q[15:0];
  assign bus_we       = we_q;
  assign ep_tx_addr_0 = addr_q[8:0];
  assign ep_tx_data_0 = wdata_q;
  assign ep_rx_addr_0 = addr_q[8:0];

`ifdef USB_WB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       err_q;

  // Expiry is the cycle the count would reach zero; bus_ack in that
  // same cycle takes priority.
  assign abort = (state == CORE) && !bus_ack && (tmo_cnt == 8'd1);
  assign err_timeout = err_q;

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      if (load)
        tmo_cnt <= 8'(TIMEOUT);
      else if ((state == CORE) && !bus_ack)
        tmo_cnt <= tmo_cnt - 8'd1;
      if (abort)
        err_q <= 1'b1;
    end
  end
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT;
  assign abort       = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // State, request capture and read-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= 12'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state   <= state_nxt;
      rdata_q <= rdata_nxt;
      if (load) begin
        addr_q  <= wb_addr[11:0];
        wdata_q <= wb_wdata;
        we_q    <= wb_we;
      end
    end
  end

  // Next-state and read-data selection; wb_cyc is ignored once a request
  // is taken so the core/EP access always completes.
  always_comb begin
    state_nxt = state;
    rdata_nxt = rdata_q;
    case (state)
      IDLE: begin
        if (load) begin
          rdata_nxt = 32'h0;
          case (wb_addr[15:14])
            2'b00:   state_nxt = CORE;
            2'b01:   state_nxt = wb_we ? TXW : ACK;
            2'b10:   state_nxt = wb_we ? ACK : RXR;
            default: state_nxt = ACK;
          endcase
        end
      end
      CORE: begin
        if (bus_ack) begin
          rdata_nxt = {16'h0, bus_dout};
          state_nxt = ACK;
        end else if (abort) begin
          rdata_nxt = 32'hFFFF_FFFF;
          state_nxt = ACK;
        end
      end
      TXW: state_nxt = ACK;
      RXR: state_nxt = RXD;
      RXD: begin
        rdata_nxt = ep_rx_data_1;
        state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_wb_bridge.sv
// Bench for usb_wb_bridge: per-cycle expectation table built from the
// transaction rules, a core/RX-buffer model, directed and random traffic.
module tb_usb_wb_bridge;
  localparam int TO = 10;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [15:0] wb_addr = 0;
  logic [31:0] wb_wdata = 0;
  logic [31:0] wb_rdata;
  logic        wb_we = 0;
  logic        wb_cyc = 0;
  logic        wb_ack;
  logic [15:0] bus_addr, bus_din;
  logic [15:0] bus_dout = 0;
  logic        bus_cyc, bus_we;
  logic        bus_ack = 0;
  logic [8:0]  ep_tx_addr_0, ep_rx_addr_0;
  logic [31:0] ep_tx_data_0;
  logic        ep_tx_we_0, ep_rx_re_0;
  logic [31:0] ep_rx_data_1 = 0;
  logic        err_timeout;

  usb_wb_bridge #(.ADDR_MSB(4'h3), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .wb_rdata(wb_rdata), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
    .bus_addr(bus_addr), .bus_din(bus_din), .bus_dout(bus_dout),
    .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_ack(bus_ack),
    .ep_tx_addr_0(ep_tx_addr_0), .ep_tx_data_0(ep_tx_data_0),
    .ep_tx_we_0(ep_tx_we_0), .ep_rx_addr_0(ep_rx_addr_0),
    .ep_rx_data_1(ep_rx_data_1), .ep_rx_re_0(ep_rx_re_0),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // edge_n = number of rising edges so far; "cycle k" is the interval after edge k
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    bit          ack;
    logic [31:0] rd;
    bit          cyc;
    logic [15:0] badr;
    logic [15:0] bdin;
    bit          bwe;
    bit          tx;
    logic [8:0]  txa;
    logic [31:0] txd;
    bit          rx;
    logic [8:0]  rxa;
  } exp_t;

  exp_t        exp_q[int];
  int          err_edge = 32'h7fff_ffff;
  int          free_edge = 0;
  bit          chk_en = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] rx_mem [512];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, edge_n, got, want);
    end
  endtask

  function automatic exp_t ezero();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  // RX buffer model: registered read, like the core's EP RAM.
  always @(posedge clk) if (ep_rx_re_0) ep_rx_data_1 <= rx_mem[ep_rx_addr_0];

  // Snoop counters and last-seen values used by directed literal checks.
  int          strobes = 0, tx_cnt = 0, rx_cnt = 0, ack_edge = 0;
  logic        cyc_prev = 0;
  logic [31:0] ack_data = 0, tx_d = 0;
  logic [15:0] s_badr = 0, s_bdin = 0;
  logic        s_bwe = 0;
  logic [8:0]  tx_a = 0;
  always @(negedge clk) begin
    cyc_prev <= bus_cyc;
    if (bus_cyc && !cyc_prev) strobes <= strobes + 1;
    if (bus_cyc && bus_ack) begin
      s_badr <= bus_addr; s_bdin <= bus_din; s_bwe <= bus_we;
    end
    if (wb_ack) begin ack_edge <= edge_n; ack_data <= wb_rdata; end
    if (ep_tx_we_0) begin tx_cnt <= tx_cnt + 1; tx_a <= ep_tx_addr_0; tx_d <= ep_tx_data_0; end
    if (ep_rx_re_0) rx_cnt <= rx_cnt + 1;
  end

  // Compare every cycle against the expectation table.
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (chk_en) begin
      k = edge_n;
      e = ezero();
      if (exp_q.exists(k)) e = exp_q[k];
      chk("wb_ack", wb_ack, e.ack);
      chk("wb_rdata", wb_rdata, e.ack ? e.rd : 32'h0);
      chk("bus_cyc", bus_cyc, e.cyc);
      if (e.cyc) begin
        chk("bus_addr", bus_addr, e.badr);
        chk("bus_din", bus_din, e.bdin);
        chk("bus_we", bus_we, e.bwe);
      end
      chk("ep_tx_we_0", ep_tx_we_0, e.tx);
      if (e.tx) begin
        chk("ep_tx_addr_0", ep_tx_addr_0, e.txa);
        chk("ep_tx_data_0", ep_tx_data_0, e.txd);
      end
      chk("ep_rx_re_0", ep_rx_re_0, e.rx);
      if (e.rx) chk("ep_rx_addr_0", ep_rx_addr_0, e.rxa);
      chk("err_timeout", err_timeout, k >= err_edge);
    end
  end

  task automatic wait_edge(input int k);
    while (edge_n < k) begin @(posedge clk); #1; end
  endtask

  // One Wishbone transaction: fills the expectation table, plays the core
  // side, and returns the sampling edge n and the ack cycle a.
  task automatic issue(input logic [15:0] adr, input logic we, input logic [31:0] d,
                       input int dly, input bit drop, output int n, output int a);
    exp_t        e;
    logic [15:0] dout;
    int          m;
    bit          ab;
    wait_edge(free_edge - 1);
    wb_addr = adr; wb_we = we; wb_wdata = d; wb_cyc = 1;
    n = edge_n + 1;
    m = dly; ab = 0;
    dout = 16'($urandom);
    case (adr[15:14])
      2'b00: begin
`ifdef USB_WB_TIMEOUT_EN
        if (dly > TO) begin m = TO; ab = 1; end
`endif
        a = n + m;
        for (int c = n; c < a; c++) begin
          e = ezero(); e.cyc = 1; e.badr = {4'h3, adr[11:0]}; e.bdin = d[15:0]; e.bwe = we;
          exp_q[c] = e;
        end
        e = ezero(); e.ack = 1; e.rd = ab ? 32'hFFFF_FFFF : {16'h0, dout};
        exp_q[a] = e;
        if (ab && a < err_edge) err_edge = a;
      end
      2'b01: begin
        if (we) begin
          e = ezero(); e.tx = 1; e.txa = adr[8:0]; e.txd = d; exp_q[n] = e;
          a = n + 1;
        end else a = n;
        e = ezero(); e.ack = 1; e.rd = 32'h0; exp_q[a] = e;
      end
      2'b10: begin
        if (!we) begin
          e = ezero(); e.rx = 1; e.rxa = adr[8:0]; exp_q[n] = e;
          a = n + 2;
          e = ezero(); e.ack = 1; e.rd = rx_mem[adr[8:0]]; exp_q[a] = e;
        end else begin
          a = n;
          e = ezero(); e.ack = 1; e.rd = 32'h0; exp_q[a] = e;
        end
      end
      default: begin
        a = n;
        e = ezero(); e.ack = 1; e.rd = 32'h0; exp_q[a] = e;
      end
    endcase
    if (drop) begin wait_edge(n); wb_cyc = 0; end
    if (adr[15:14] == 2'b00 && !ab) begin
      wait_edge(a - 1);
      bus_ack = 1; bus_dout = dout;
      wait_edge(a);
      bus_ack = 0; bus_dout = 16'($urandom);
    end
    wait_edge(a + 1);
    free_edge = a + 2;
  endtask

  int n, a, a0, s0, t0, r0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) rx_mem[i] = $urandom;
    rx_mem[9'h1FF] = 32'h1234_5678;

    // reset state
    wait_edge(3);
    chk("rst wb_ack", wb_ack, 0);
    chk("rst wb_rdata", wb_rdata, 0);
    chk("rst bus_addr", bus_addr, 16'h3000);
    chk("rst bus_din", bus_din, 0);
    chk("rst bus_cyc", bus_cyc, 0);
    chk("rst bus_we", bus_we, 0);
    chk("rst ep_tx", {ep_tx_we_0, ep_tx_addr_0, ep_tx_data_0 != 0}, 0);
    chk("rst ep_rx", {ep_rx_re_0, ep_rx_addr_0}, 0);
    chk("rst err_timeout", err_timeout, 0);
    rst_n = 1;
    free_edge = edge_n + 2;
    wait_edge(edge_n + 1);
    chk_en = 1;

    // CSR write through the core bus
    s0 = strobes;
    issue(16'h0000, 1'b1, 32'h0000_C012, 2, 0, n, a);
    wb_cyc = 0;
    chk("csr ack latency", ack_edge - n, 2);
    chk("csr bus_addr", s_badr, 16'h3000);
    chk("csr bus_din", s_bdin, 16'hC012);
    chk("csr bus_we", s_bwe, 1);
    chk("csr strobes", strobes - s0, 1);

    // EP TX write
    t0 = tx_cnt;
    issue(16'h4012, 1'b1, 32'hA5A5_5A5A, 1, 0, n, a);
    chk("tx ack latency", ack_edge - n, 1);
    chk("tx addr", tx_a, 9'h012);
    chk("tx data", tx_d, 32'hA5A5_5A5A);
    chk("tx pulses", tx_cnt - t0, 1);

    // EP RX read
    r0 = rx_cnt;
    issue(16'h81FF, 1'b0, 32'h0, 1, 0, n, a);
    chk("rx ack latency", ack_edge - n, 2);
    chk("rx data", ack_data, 32'h1234_5678);
    chk("rx pulses", rx_cnt - r0, 1);

    // back-to-back with wb_cyc held: unmapped read then dropped RX write
    issue(16'hC000, 1'b0, 32'h0, 1, 0, n, a0);
    chk("unmapped read", ack_data, 32'h0);
    r0 = rx_cnt;
    issue(16'h8000, 1'b1, 32'hDEAD_BEEF, 1, 0, n, a);
    chk("b2b ack spacing", a - a0, 2);
    chk("rx write no re", rx_cnt - r0, 0);
    wb_cyc = 0;

`ifdef USB_WB_TIMEOUT_EN
    issue(16'h0004, 1'b0, 32'h0, 1000, 0, n, a);
    chk("tmo latency", ack_edge - n, TO);
    chk("tmo data", ack_data, 32'hFFFF_FFFF);
    chk("tmo err", err_timeout, 1);
    issue(16'h0008, 1'b0, 32'h0, TO, 0, n, a);
    chk("tmo race data hi", ack_data[31:16], 16'h0);
    chk("tmo race err", err_timeout, 1);
    wb_cyc = 0;
`endif

    // reset in the middle of a core access
    wait_edge(free_edge - 1);
    chk_en = 0;
    wb_addr = 16'h0010; wb_we = 0; wb_cyc = 1;
    n = edge_n + 1;
    wait_edge(n + 2);
    chk("pre-reset bus_cyc", bus_cyc, 1);
    #2 rst_n = 0;
    #1;
    chk("async bus_cyc", bus_cyc, 0);
    chk("async wb_ack", wb_ack, 0);
    wb_cyc = 0;
    wait_edge(edge_n + 2);
    chk("post-rst bus_addr", bus_addr, 16'h3000);
    chk("post-rst err", err_timeout, 0);
    rst_n = 1;
    err_edge = 32'h7fff_ffff;
    free_edge = edge_n + 2;
    wait_edge(edge_n + 1);
    chk_en = 1;

    // random traffic
    for (int t = 0; t < 300; t++) begin
      logic [15:0] ra;
      logic        rw;
      logic [31:0] rd;
      int          dl, gap;
      bit          dr;
      ra = 16'($urandom); rw = 1'($urandom); rd = $urandom;
      dl = $urandom_range(8, 1);
`ifdef USB_WB_TIMEOUT_EN
      if ($urandom_range(5, 0) == 0) dl = $urandom_range(TO + 3, TO - 1);
`endif
      dr = ($urandom_range(7, 0) == 0);
      issue(ra, rw, rd, dl, dr, n, a);
      gap = $urandom_range(2, 0);
      if (gap != 0) begin wb_cyc = 0; wait_edge(edge_n + gap); end
    end
    wb_cyc = 0;
    wait_edge(edge_n + 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
